// File: rtl/osc_cmd_rx.sv
// osc_cmd_rx: 8N1 UART receiver feeding a 4-byte command-frame parser
// (0xA5, CMD, DATA, CHK) that drives the capture control registers.
module osc_cmd_rx #(
   parameter int CLK_DIV      = 434,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic       rx_ferr,
   output logic       cmd_valid,
   output logic [7:0] cmd,
   output logic [7:0] cmd_data,
   output logic       chk_err,
   output logic       cmd_err,
   output logic [7:0] trig_level,
   output logic       run,
   output logic [3:0] decim
);
   localparam int CW     = $clog2(CLK_DIV);
   localparam int TO_CYC = TIMEOUT_BITS * CLK_DIV;
   localparam int TW     = $clog2(TO_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;
   typedef enum logic [1:0] {P_HDR, P_CMD, P_DATA, P_CHK} p_state_t;

   logic            rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
   rx_state_t       rx_st_q, rx_st_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            rx_byte_valid_q, rx_byte_valid_d, rx_ferr_q, rx_ferr_d;
   p_state_t        p_st_q, p_st_d;
   logic [7:0]      cmd_tmp_q, cmd_tmp_d, data_tmp_q, data_tmp_d;
   logic [TW-1:0]   idle_q, idle_d;
   logic [7:0]      cmd_q, cmd_d, cmd_data_q, cmd_data_d, trig_q, trig_d;
   logic            cmd_valid_q, cmd_valid_d, chk_err_q, chk_err_d, cmd_err_q, cmd_err_d;
   logic            run_q, run_d;
   logic [3:0]      decim_q, decim_d;

   // Synchroniser chain and edge-detect history
   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      rx_prev_d = rx_s_q;
   end

   // UART receive FSM: mid-bit sampling, LSB first, stop-bit framing check
   always_comb begin
      rx_st_d         = rx_st_q;
      cnt_d           = cnt_q;
      bit_idx_d       = bit_idx_q;
      shreg_d         = shreg_q;
      rx_byte_d       = rx_byte_q;
      rx_byte_valid_d = 1'b0;
      rx_ferr_d       = 1'b0;
      unique case (rx_st_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               rx_st_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CW'(CLK_DIV/2 - 1)) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               rx_st_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = CW'(cnt_q + 1'b1);
            end
         end
         S_DATA: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d   = '0;
               shreg_d = {rx_s_q, shreg_q[7:1]};
               if (bit_idx_q == 3'd7) rx_st_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = CW'(cnt_q + 1'b1);
            end
         end
         S_STOP: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  rx_byte_d       = shreg_q;
                  rx_byte_valid_d = 1'b1;
                  rx_st_d         = S_IDLE;
               end else begin
                  rx_ferr_d = 1'b1;
                  rx_st_d   = S_BREAK;
               end
            end else begin
               cnt_d = CW'(cnt_q + 1'b1);
            end
         end
         S_BREAK: begin
            if (rx_s_q) rx_st_d = S_IDLE;
         end
         default: rx_st_d = S_IDLE;
      endcase
   end

   // Frame parser, silence timeout and control-register updates.
   // Silence only accrues while the receiver is idle, so a byte in flight
   // never counts toward the timeout regardless of TIMEOUT_BITS.
   always_comb begin
      p_st_d      = p_st_q;
      cmd_tmp_d   = cmd_tmp_q;
      data_tmp_d  = data_tmp_q;
      idle_d      = '0;
      cmd_d       = cmd_q;
      cmd_data_d  = cmd_data_q;
      trig_d      = trig_q;
      run_d       = run_q;
      decim_d     = decim_q;
      cmd_valid_d = 1'b0;
      chk_err_d   = 1'b0;
      cmd_err_d   = 1'b0;
      if (rx_ferr_q) begin
         p_st_d = P_HDR;
      end else if (rx_byte_valid_q) begin
         unique case (p_st_q)
            P_HDR:  if (rx_byte_q == 8'hA5) p_st_d = P_CMD;
            P_CMD:  begin cmd_tmp_d  = rx_byte_q; p_st_d = P_DATA; end
            P_DATA: begin data_tmp_d = rx_byte_q; p_st_d = P_CHK;  end
            P_CHK: begin
               p_st_d = P_HDR;
               if (rx_byte_q != (cmd_tmp_q ^ data_tmp_q)) begin
                  chk_err_d = 1'b1;
               end else begin
                  unique case (cmd_tmp_q)
                     8'h01:   trig_d  = data_tmp_q;
                     8'h02:   run_d   = data_tmp_q[0];
                     8'h03:   decim_d = data_tmp_q[3:0];
                     default: cmd_err_d = 1'b1;
                  endcase
                  if (!cmd_err_d) begin
                     cmd_valid_d = 1'b1;
                     cmd_d       = cmd_tmp_q;
                     cmd_data_d  = data_tmp_q;
                  end
               end
            end
            default: p_st_d = P_HDR;
         endcase
      end else if (p_st_q != P_HDR && rx_st_q == S_IDLE) begin
         if (idle_q == TW'(TO_CYC - 1)) p_st_d = P_HDR;
         else                          idle_d = TW'(idle_q + 1'b1);
      end
   end

   // State registers; synchroniser resets to line-idle level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;  rx_s_q <= 1'b1;  rx_prev_q <= 1'b1;
         rx_st_q <= S_IDLE;  cnt_q <= '0;  bit_idx_q <= '0;  shreg_q <= '0;
         rx_byte_q <= '0;  rx_byte_valid_q <= 1'b0;  rx_ferr_q <= 1'b0;
         p_st_q <= P_HDR;  cmd_tmp_q <= '0;  data_tmp_q <= '0;  idle_q <= '0;
         cmd_q <= '0;  cmd_data_q <= '0;  trig_q <= '0;  run_q <= 1'b0;  decim_q <= '0;
         cmd_valid_q <= 1'b0;  chk_err_q <= 1'b0;  cmd_err_q <= 1'b0;
      end else begin
         rx_meta_q <= rx_meta_d;  rx_s_q <= rx_s_d;  rx_prev_q <= rx_prev_d;
         rx_st_q <= rx_st_d;  cnt_q <= cnt_d;  bit_idx_q <= bit_idx_d;  shreg_q <= shreg_d;
         rx_byte_q <= rx_byte_d;  rx_byte_valid_q <= rx_byte_valid_d;  rx_ferr_q <= rx_ferr_d;
         p_st_q <= p_st_d;  cmd_tmp_q <= cmd_tmp_d;  data_tmp_q <= data_tmp_d;  idle_q <= idle_d;
         cmd_q <= cmd_d;  cmd_data_q <= cmd_data_d;  trig_q <= trig_d;  run_q <= run_d;
         decim_q <= decim_d;
         cmd_valid_q <= cmd_valid_d;  chk_err_q <= chk_err_d;  cmd_err_q <= cmd_err_d;
      end
   end

   assign rx_byte       = rx_byte_q;
   assign rx_byte_valid = rx_byte_valid_q;
   assign rx_ferr       = rx_ferr_q;
   assign cmd_valid     = cmd_valid_q;
   assign cmd           = cmd_q;
   assign cmd_data      = cmd_data_q;
   assign chk_err       = chk_err_q;
   assign cmd_err       = cmd_err_q;
   assign trig_level    = trig_q;
   assign run           = run_q;
   assign decim         = decim_q;
endmodule

// File: tb/tb_osc_cmd_rx.sv
// Scoreboard bench for osc_cmd_rx: stimulus tasks push expected events from
// a frame-level model; a negedge monitor pops and compares DUT pulses.
module tb_osc_cmd_rx;
   localparam int CLK_DIV      = 8;
   localparam int TIMEOUT_BITS = 4;

   logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
   logic [7:0] rx_byte, cmd, cmd_data, trig_level;
   logic       rx_byte_valid, rx_ferr, cmd_valid, chk_err, cmd_err, run;
   logic [3:0] decim;

   osc_cmd_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .rx_byte(rx_byte),
      .rx_byte_valid(rx_byte_valid), .rx_ferr(rx_ferr), .cmd_valid(cmd_valid),
      .cmd(cmd), .cmd_data(cmd_data), .chk_err(chk_err), .cmd_err(cmd_err),
      .trig_level(trig_level), .run(run), .decim(decim));

   always #5 clk = ~clk;

   typedef struct {
      int         kind;   // 0 byte, 1 ferr, 2 cmd_valid, 3 chk_err, 4 cmd_err
      logic [7:0] b;
      logic [28:0] regs;  // {cmd, cmd_data, trig, run, decim}
   } ev_t;

   ev_t        sb[$];
   logic [7:0] frm[$];
   logic [7:0] m_cmd, m_data, m_trig;
   logic       m_run;
   logic [3:0] m_decim;
   int         checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [28:0] mregs();
      return {m_cmd, m_data, m_trig, m_run, m_decim};
   endfunction

   task automatic push(input int kind, input logic [7:0] b);
      ev_t e;
      e.kind = kind; e.b = b; e.regs = mregs();
      sb.push_back(e);
   endtask

   task automatic model_reset();
      sb.delete(); frm.delete();
      m_cmd = 0; m_data = 0; m_trig = 0; m_run = 0; m_decim = 0;
   endtask

   // Frame-level model: collect header-aligned 4-byte frames, act on the 4th
   task automatic model_byte(input logic [7:0] b);
      logic [7:0] c, d, k;
      push(0, b);
      if (frm.size() == 0) begin
         if (b == 8'hA5) frm.push_back(b);
      end else begin
         frm.push_back(b);
         if (frm.size() == 4) begin
            c = frm[1]; d = frm[2]; k = frm[3];
            frm.delete();
            if (k != (c ^ d)) push(3, 0);
            else if (c == 8'h01 || c == 8'h02 || c == 8'h03) begin
               if (c == 8'h01) m_trig = d;
               if (c == 8'h02) m_run = d[0];
               if (c == 8'h03) m_decim = d[3:0];
               m_cmd = c; m_data = d;
               push(2, 0);
            end else push(4, 0);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      if (stop) model_byte(b);
      else begin push(1, 0); frm.delete(); end
      rx = 1'b0; cyc(CLK_DIV);
      for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(CLK_DIV); end
      rx = stop; cyc(CLK_DIV);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
      send_byte(8'hA5, 1'b1); cyc(2);
      send_byte(c, 1'b1);     cyc(2);
      send_byte(d, 1'b1);     cyc(2);
      send_byte(k, 1'b1);     cyc(CLK_DIV);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 2000) begin cyc(1); t++; end
      check(name, sb.size(), 0);
   endtask

   task automatic check_all_zero(input string name);
      @(negedge clk);
      check(name, {rx_byte, rx_byte_valid, rx_ferr, cmd_valid, cmd, cmd_data,
                   chk_err, cmd_err, trig_level, run, decim}, 0);
   endtask

   // Monitor: every output pulse must match the next expected event
   int   mon_kind, mon_n;
   ev_t  mon_e;
   always @(negedge clk) begin
      if (rst_n && (rx_byte_valid || rx_ferr || cmd_valid || chk_err || cmd_err)) begin
         mon_n = int'(rx_byte_valid) + int'(rx_ferr) + int'(cmd_valid) + int'(chk_err) + int'(cmd_err);
         check("pulse_exclusive", mon_n, 1);
         mon_kind = rx_byte_valid ? 0 : rx_ferr ? 1 : cmd_valid ? 2 : chk_err ? 3 : 4;
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event kind=%0d at %0t", mon_kind, $time);
         end else begin
            mon_e = sb.pop_front();
            check("event_kind", mon_kind, mon_e.kind);
            if (mon_kind == 0) check("rx_byte", rx_byte, mon_e.b);
            if (mon_kind >= 2)
               check("regs_after_frame", {cmd, cmd_data, trig_level, run, decim}, mon_e.regs);
         end
      end
   end

   initial begin
      logic [7:0] c, d, k, nb;
      model_reset();
      cyc(3); rst_n = 1'b1;
      check_all_zero("reset_outputs");
      cyc(2 * CLK_DIV);

      // 1: good trig_level frame
      send_frame(8'h01, 8'h80, 8'h81); drain("t1_drain");
      // 2: bad checksum
      send_frame(8'h02, 8'h01, 8'h00); drain("t2_drain");
      check("t2_run", run, 0);
      // 3: unknown command
      send_frame(8'h07, 8'h11, 8'h16); drain("t3_drain");
      // 4: glitch, then framing error
      rx = 1'b0; cyc(2); rx = 1'b1; cyc(3 * CLK_DIV);
      send_byte(8'h5A, 1'b0); cyc(2 * CLK_DIV); drain("t4_drain");
      // 5: partial frame abandoned by silence
      send_byte(8'hA5, 1'b1); cyc(2); send_byte(8'h01, 1'b1);
      cyc(40 * CLK_DIV); frm.delete();
      send_frame(8'h03, 8'h05, 8'h06); drain("t5_drain");
      check("t5_decim", decim, 5);
      // 6: reset during DATA of the CMD byte
      send_byte(8'hA5, 1'b1); cyc(2); drain("t6_hdr");
      rx = 1'b0; cyc(CLK_DIV);
      rx = 1'b0; cyc(CLK_DIV); rx = 1'b1; cyc(CLK_DIV); rx = 1'b0; cyc(CLK_DIV / 2);
      rst_n = 1'b0; rx = 1'b1; model_reset(); cyc(1); rst_n = 1'b1;
      check_all_zero("t6_reset_outputs");
      cyc(3 * CLK_DIV);
      send_frame(8'h02, 8'h01, 8'h03); drain("t6_drain");
      check("t6_run", run, 1);

      // Randomized frames with noise bytes, bad checksums, unknown cmds, framing errors
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0) begin
            nb = 8'($urandom_range(255));
            if (nb == 8'hA5) nb = 8'h5A;
            send_byte(nb, 1'b1); cyc($urandom_range(12));
         end
         c = 8'($urandom_range(4));
         if ($urandom_range(4) == 0) c = 8'($urandom_range(255));
         d = 8'($urandom_range(255));
         k = ($urandom_range(3) == 0) ? (c ^ d ^ 8'($urandom_range(1, 255))) : (c ^ d);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(15) == 0) begin
               send_byte(8'($urandom_range(255)), 1'b0); cyc(CLK_DIV);
            end
            send_byte((i == 0) ? 8'hA5 : (i == 1) ? c : (i == 2) ? d : k, 1'b1);
            cyc($urandom_range(12));
         end
         cyc(40 * CLK_DIV); frm.delete();
         drain("rand_drain");
      end

      check("final_regs", {cmd, cmd_data, trig_level, run, decim}, mregs());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
